// File: rtl/event_pkg.sv
// Shared definitions for the event readout path: AXI encodings, page size
// and the readout master state encoding.
package event_pkg;

  localparam logic [1:0] AXI_BURST_INCR       = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY        = 2'b00;
  localparam logic [3:0] AXI_CACHE_BUFFERABLE = 4'b0011;
  localparam int unsigned PAGE_BYTES          = 4096;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } rd_state_e;

endpackage

// File: rtl/axis_reg_slice.sv
// Single-stage valid/ready register carrying tdata and tlast.
// Ports:
//   aclk, rst              clock, synchronous active-high reset
//   s_tdata_i/s_tlast_i    upstream beat, s_tvalid_i/s_tready_o handshake
//   m_tdata_o/m_tlast_o    registered beat, m_tvalid_o/m_tready_i handshake
module axis_reg_slice #(
  parameter int DATA_WIDTH = 512
) (
  input  logic                  aclk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_tdata_i,
  input  logic                  s_tlast_i,
  input  logic                  s_tvalid_i,
  output logic                  s_tready_o,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic                  m_tlast_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i
);

  logic                  vld_q;
  logic                  last_q;
  logic [DATA_WIDTH-1:0] data_q;

  // The register can take a new beat when empty or while its beat leaves.
  assign s_tready_o = !vld_q || m_tready_i;

  always_ff @(posedge aclk) begin
    if (rst) begin
      vld_q  <= 1'b0;
      last_q <= 1'b0;
    end else if (s_tready_o) begin
      vld_q  <= s_tvalid_i;
      last_q <= s_tvalid_i && s_tlast_i;
    end
  end

  always_ff @(posedge aclk) begin
    if (s_tready_o && s_tvalid_i) data_q <= s_tdata_i;
  end

  assign m_tdata_o  = data_q;
  assign m_tlast_o  = last_q;
  assign m_tvalid_o = vld_q;

endmodule

// File: rtl/event_readout_master.sv
// AXI4 read initiator draining events from DDR into a stream.
// A (base address, beat count) command is split into INCR bursts that never
// cross a 4 KB page, with a bounded number of bursts in flight. Read data
// passes through one output register; tlast marks the command's final beat.
// Ports:
//   aclk, rst                       clock, synchronous active-high reset
//   cmd_addr/cmd_len/cmd_valid/ready command handshake (accepted in IDLE only)
//   m_axi_ar*                       AXI read address channel
//   m_axi_r*                        AXI read data channel
//   m_axis_t*                       output stream
//   done/err                        one-cycle completion pulse, error flag
module event_readout_master
  import event_pkg::*;
#(
  parameter int ADDR_WIDTH      = 34,
  parameter int DATA_WIDTH      = 512,
  parameter int MAX_BURST       = 64,
  parameter int MAX_OUTSTANDING = 4,
  parameter int LEN_WIDTH       = 16
) (
  input  logic                  aclk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  done,
  output logic                  err
);

  localparam int BPB = DATA_WIDTH / 8;
  localparam int OFF = $clog2(BPB);
  localparam int CW  = (LEN_WIDTH > 13) ? LEN_WIDTH + 1 : 14;
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);

  rd_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] ar_addr_q, araddr_q;
  logic [LEN_WIDTH-1:0]  ar_rem_q, r_rem_q;
  logic [7:0]            arlen_q;
  logic                  arvalid_q;
  logic [OW-1:0]         outstanding_q;
  logic                  err_q;

  logic        cmd_hs, ar_hs, r_hs, out_inc, out_dec, issue;
  logic [12:0] page_left;
  logic [CW-1:0] btb, blen;

  assign cmd_ready = (state_q == ST_IDLE) && !rst;
  assign cmd_hs    = cmd_valid && cmd_ready;
  assign ar_hs     = arvalid_q && m_axi_arready;
  assign r_hs      = m_axi_rvalid && m_axi_rready;
  assign out_inc   = ar_hs;
  assign out_dec   = r_hs && m_axi_rlast && (outstanding_q != '0);

  // 13 bits so a page-aligned address yields the full 4096 bytes.
  assign page_left = 13'(PAGE_BYTES) - {1'b0, ar_addr_q[11:0]};
  assign btb       = CW'(page_left >> OFF);

  always_comb begin
    blen = CW'(ar_rem_q);
    if (blen > CW'(MAX_BURST)) blen = CW'(MAX_BURST);
    if (blen > btb)            blen = btb;
  end

  // One burst is prepared at a time; the next is registered only after the
  // current address handshake has updated ar_addr/ar_rem.
  assign issue = (state_q == ST_ISSUE) && !arvalid_q && (ar_rem_q != '0) &&
                 (outstanding_q < OW'(MAX_OUTSTANDING));

  always_comb begin
    state_d = state_q;
    case (state_q)
      // An empty command passes through DRAIN, which finds nothing pending,
      // so its done pulse lands two cycles after the handshake.
      ST_IDLE:  if (cmd_hs) state_d = (cmd_len != '0) ? ST_ISSUE : ST_DRAIN;
      ST_ISSUE: if ((ar_rem_q == '0) && !arvalid_q) state_d = ST_DRAIN;
      ST_DRAIN: if ((r_rem_q == '0) && (!m_axis_tvalid || m_axis_tready)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      ar_addr_q     <= '0;
      ar_rem_q      <= '0;
      r_rem_q       <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      arvalid_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cmd_hs) begin
        ar_addr_q <= cmd_addr & ~ADDR_WIDTH'(BPB - 1);
        ar_rem_q  <= cmd_len;
        r_rem_q   <= cmd_len;
        err_q     <= 1'b0;
      end else begin
        if (ar_hs) begin
          ar_addr_q <= ar_addr_q + ((ADDR_WIDTH'(arlen_q) + ADDR_WIDTH'(1)) << OFF);
          ar_rem_q  <= ar_rem_q - (LEN_WIDTH'(arlen_q) + LEN_WIDTH'(1));
        end
        if (r_hs && (r_rem_q != '0)) r_rem_q <= r_rem_q - LEN_WIDTH'(1);
        if (r_hs && (m_axi_rresp != AXI_RESP_OKAY)) err_q <= 1'b1;
      end
      if (ar_hs)      arvalid_q <= 1'b0;
      else if (issue) arvalid_q <= 1'b1;
      if (out_inc && !out_dec)      outstanding_q <= outstanding_q + OW'(1);
      else if (out_dec && !out_inc) outstanding_q <= outstanding_q - OW'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (issue) begin
      araddr_q <= ar_addr_q;
      arlen_q  <= 8'(blen - CW'(1));
    end
  end

  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_arsize  = 3'(OFF);
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arcache = AXI_CACHE_BUFFERABLE;
  assign m_axi_arprot  = 3'b000;

  axis_reg_slice #(.DATA_WIDTH(DATA_WIDTH)) u_out (
    .aclk       (aclk),
    .rst        (rst),
    .s_tdata_i  (m_axi_rdata),
    .s_tlast_i  (r_rem_q == LEN_WIDTH'(1)),
    .s_tvalid_i (m_axi_rvalid),
    .s_tready_o (m_axi_rready),
    .m_tdata_o  (m_axis_tdata),
    .m_tlast_o  (m_axis_tlast),
    .m_tvalid_o (m_axis_tvalid),
    .m_tready_i (m_axis_tready)
  );

  assign done = (state_q == ST_DONE);
  assign err  = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_event_readout_master.sv
module tb_event_readout_master;

  localparam int AW = 34;
  localparam int DW = 512;
  localparam int LW = 16;

  logic          aclk;
  logic          rst;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          cmd_valid, cmd_ready;
  logic [AW-1:0] m_axi_araddr;
  logic [7:0]    m_axi_arlen;
  logic [2:0]    m_axi_arsize;
  logic [1:0]    m_axi_arburst;
  logic [3:0]    m_axi_arcache;
  logic [2:0]    m_axi_arprot;
  logic          m_axi_arvalid, m_axi_arready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rlast, m_axi_rvalid, m_axi_rready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast, m_axis_tvalid, m_axis_tready;
  logic          done, err;

  event_readout_master dut (
    .aclk(aclk), .rst(rst),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .done(done), .err(err)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Controls written by the directed sequence, read by the slave model.
  bit          arready_en = 1'b1;
  int unsigned r_delay    = 1;
  int unsigned err_beat   = 0;
  int unsigned tready_pct = 100;

  // Slave model and monitor state.
  int unsigned ar_q_len[$];
  int unsigned ar_q_time[$];
  longint      ar_log_addr[$];
  longint      ar_log_len[$];
  longint      ar_log_cyc[$];
  logic [DW-1:0] rx_data[$];
  bit          rx_last[$];
  int unsigned cyc = 0, beat_cnt = 0, cmd_start = 0, r_beat = 0;
  int          out_model = 0, max_out = 0, ar_before_rlast = 0, rready_viol = 0;
  bit          rlast_seen = 0;
  longint      hs_cyc = 0, last_hs_cyc = 0, done_cyc = 0;
  int          done_cnt = 0;
  logic        done_err = 1'b0;

  int checks = 0;
  int errors = 0;

  // Inputs change on the falling edge; after 1 time unit the values that the
  // next rising edge will sample are stable, so handshakes are recorded then.
  initial begin
    m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rdata = '0;
    m_axi_rresp = 2'b00; m_axi_rlast = 1'b0; m_axis_tready = 1'b0;
    forever begin
      @(negedge aclk);
      if (rst) begin
        ar_q_len.delete(); ar_q_time.delete(); r_beat = 0; out_model = 0;
      end
      m_axi_arready = arready_en;
      if (ar_q_len.size() > 0 && cyc >= ar_q_time[0] + r_delay) begin
        m_axi_rvalid = 1'b1;
        m_axi_rdata  = {16{beat_cnt}};
        m_axi_rlast  = (r_beat == ar_q_len[0]);
        m_axi_rresp  = (err_beat != 0 && beat_cnt - cmd_start + 1 == err_beat) ? 2'b10 : 2'b00;
      end else begin
        m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0; m_axi_rresp = 2'b00;
      end
      m_axis_tready = ($urandom_range(99) < tready_pct);
      #1;
      if (cmd_valid && cmd_ready) begin
        hs_cyc = cyc; cmd_start = beat_cnt; rlast_seen = 0; ar_before_rlast = 0; max_out = 0;
      end
      if (m_axi_arvalid && m_axi_arready) begin
        ar_q_len.push_back(m_axi_arlen); ar_q_time.push_back(cyc);
        ar_log_addr.push_back(m_axi_araddr); ar_log_len.push_back(m_axi_arlen);
        ar_log_cyc.push_back(cyc);
        out_model++;
        if (!rlast_seen) ar_before_rlast++;
      end
      if (m_axi_rvalid && m_axi_rready) begin
        beat_cnt++;
        if (m_axi_rlast) begin
          void'(ar_q_len.pop_front()); void'(ar_q_time.pop_front());
          r_beat = 0; out_model--; rlast_seen = 1;
        end else r_beat++;
      end
      if (out_model > max_out) max_out = out_model;
      if (m_axis_tvalid && !m_axis_tready && m_axi_rready) rready_viol++;
      if (m_axis_tvalid && m_axis_tready) begin
        rx_data.push_back(m_axis_tdata); rx_last.push_back(m_axis_tlast);
        if (m_axis_tlast) last_hs_cyc = cyc;
      end
      if (done) begin done_cnt++; done_cyc = cyc; done_err = err; end
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge aclk); #2;
  endtask

  task automatic send(input logic [AW-1:0] a, input logic [LW-1:0] l);
    @(negedge aclk); cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
    @(negedge aclk); cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < budget) begin tick(); n++; end
    check({tag, "_done"}, done_cnt - start, 1);
  endtask

  function automatic longint ar_addr_at(input int i);
    if (i < ar_log_addr.size()) return ar_log_addr[i];
    return -1;
  endfunction

  function automatic longint ar_len_at(input int i);
    if (i < ar_log_len.size()) return ar_log_len[i];
    return -1;
  endfunction

  task automatic check_stream(input string tag, input int base_rx, input int unsigned base_beat,
                              input int n);
    int bad = 0;
    logic [DW-1:0] e;
    check({tag, "_beats"}, rx_data.size() - base_rx, n);
    for (int i = 0; i < n && base_rx + i < rx_data.size(); i++) begin
      e = {16{32'(base_beat + i)}};
      if (rx_data[base_rx + i] !== e || rx_last[base_rx + i] !== (i == n - 1)) bad++;
    end
    check({tag, "_order_tlast"}, bad, 0);
  endtask

  int          b_ar, b_rx;
  int unsigned b_beat;
  longint      exp_addr[3] = '{64'hF80, 64'h1000, 64'h2000};
  longint      exp_len[3]  = '{1, 63, 33};

  initial begin
    rst = 1'b1; cmd_addr = '0; cmd_len = '0; cmd_valid = 1'b0;
    repeat (3) tick();
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_arvalid", m_axi_arvalid, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_tlast", m_axis_tlast, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("arsize", m_axi_arsize, 6);
    check("arburst", m_axi_arburst, 1);
    check("arcache", m_axi_arcache, 3);
    check("arprot", m_axi_arprot, 0);
    rst = 1'b0;
    tick();
    check("post_rst_cmd_ready", cmd_ready, 1);

    // Reset while an address is pending.
    arready_en = 1'b0;
    send(34'h0, 16'd4);
    repeat (3) tick();
    check("pend_arvalid", m_axi_arvalid, 1);
    rst = 1'b1;
    tick();
    check("midrst_arvalid", m_axi_arvalid, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    check("midrst_tvalid", m_axis_tvalid, 0);
    rst = 1'b0;
    arready_en = 1'b1;
    tick();
    check("midrst_release_cmd_ready", cmd_ready, 1);

    // Simple command.
    b_ar = ar_log_len.size(); b_rx = rx_data.size(); b_beat = beat_cnt;
    send(34'h0, 16'd10);
    wait_done("simple", 200);
    check("simple_nar", ar_log_len.size() - b_ar, 1);
    check("simple_arlen", ar_len_at(b_ar), 9);
    check("simple_araddr", ar_addr_at(b_ar), 0);
    check("simple_ar_latency", (b_ar < ar_log_cyc.size()) ? ar_log_cyc[b_ar] - hs_cyc : -1, 2);
    check_stream("simple", b_rx, b_beat, 10);
    check("simple_err", done_err, 0);
    check("simple_done_latency", done_cyc - last_hs_cyc, 1);

    // 4 KB boundary split; low address bits are ignored.
    b_ar = ar_log_len.size(); b_rx = rx_data.size(); b_beat = beat_cnt;
    send(34'hFBF, 16'd100);
    wait_done("split", 500);
    check("split_nar", ar_log_len.size() - b_ar, 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("split_araddr%0d", i), ar_addr_at(b_ar + i), exp_addr[i]);
      check($sformatf("split_arlen%0d", i), ar_len_at(b_ar + i), exp_len[i]);
    end
    check_stream("split", b_rx, b_beat, 100);
    check("split_err", done_err, 0);

    // Outstanding limit with slow read responses.
    r_delay = 50;
    b_ar = ar_log_len.size(); b_rx = rx_data.size(); b_beat = beat_cnt;
    send(34'h0, 16'd640);
    wait_done("outst", 3000);
    check("outst_nar", ar_log_len.size() - b_ar, 10);
    check("outst_before_rlast", ar_before_rlast, 4);
    check("outst_max", max_out, 4);
    check_stream("outst", b_rx, b_beat, 640);
    r_delay = 1;

    // Stream backpressure.
    tready_pct = 30;
    b_rx = rx_data.size(); b_beat = beat_cnt;
    send(34'h40, 16'd200);
    wait_done("bp", 3000);
    check_stream("bp", b_rx, b_beat, 200);
    check("bp_rready_viol", rready_viol, 0);
    check("bp_done_latency", done_cyc - last_hs_cyc, 1);
    tready_pct = 100;

    // Error response, then a clean command.
    err_beat = 3;
    send(34'h1000, 16'd8);
    wait_done("slverr", 200);
    check("slverr_err", done_err, 1);
    err_beat = 0;
    send(34'h1000, 16'd4);
    wait_done("clean", 200);
    check("clean_err", done_err, 0);

    // Empty command.
    b_ar = ar_log_len.size();
    send(34'h80, 16'd0);
    wait_done("empty", 20);
    check("empty_done_latency", done_cyc - hs_cyc, 2);
    check("empty_nar", ar_log_len.size() - b_ar, 0);
    check("empty_err", done_err, 0);

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
